// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command and result channels of the ALU operation sequencer
interface alu_op_sequencer_if;
  // command channel (upstream -> sequencer)
  logic [31:0] i_ul_cmd_a;
  logic [31:0] i_ul_cmd_b;
  logic [2:0]  i_u3_cmd_sel;
  logic        i_bi_cmd_valid;
  logic        o_bi_cmd_ready;
  // result channel (sequencer -> downstream)
  logic [31:0] o_ul_res;
  logic        o_bi_res_zflag;
  logic [2:0]  o_u3_res_sel;
  logic        o_bi_res_illegal;
  logic        o_bi_res_valid;
  logic        i_bi_res_ready;

  // upstream producer of commands and downstream consumer of results
  modport master (
    output i_ul_cmd_a, i_ul_cmd_b, i_u3_cmd_sel, i_bi_cmd_valid, i_bi_res_ready,
    input  o_bi_cmd_ready, o_ul_res, o_bi_res_zflag, o_u3_res_sel, o_bi_res_illegal,
           o_bi_res_valid
  );

  // the sequencer itself
  modport slave (
    input  i_ul_cmd_a, i_ul_cmd_b, i_u3_cmd_sel, i_bi_cmd_valid, i_bi_res_ready,
    output o_bi_cmd_ready, o_ul_res, o_bi_res_zflag, o_u3_res_sel, o_bi_res_illegal,
           o_bi_res_valid
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO feeding a registered ALU, one operation in flight
module alu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [31:0]         o_ul_a,
  output logic [31:0]         o_ul_b,
  output logic [2:0]          o_u3_sel,
  input  logic [31:0]         i_ul_r,
  input  logic                i_bi_zflag,
  output logic                o_bi_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
  } cmd_t;

  // command FIFO
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  // sequencer state and registered outputs
  state_t           state_q, state_d;
  logic [LAT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [31:0]      res_q, res_d;
  logic             zflag_q, zflag_d;
  logic [2:0]       res_sel_q, res_sel_d;
  logic             illegal_q, illegal_d;
  logic             valid_q, valid_d;

  // full comes from the registered count only, so a pop never opens room in the same cycle
  assign full               = (cnt_q == CNT_W'(DEPTH));
  assign empty              = (cnt_q == '0);
  assign push               = bus.i_bi_cmd_valid && !full;
  assign head               = mem_q[rd_ptr_q];
  assign bus.o_bi_cmd_ready = !full;

  assign o_ul_a                = a_q;
  assign o_ul_b                = b_q;
  assign o_u3_sel              = sel_q;
  assign bus.o_ul_res          = res_q;
  assign bus.o_bi_res_zflag    = zflag_q;
  assign bus.o_u3_res_sel      = res_sel_q;
  assign bus.o_bi_res_illegal  = illegal_q;
  assign bus.o_bi_res_valid    = valid_q;
  assign o_bi_busy             = (state_q != S_IDLE) || !empty;

  // storage is never read before being written, so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: bus.i_ul_cmd_a, b: bus.i_ul_cmd_b, sel: bus.i_u3_cmd_sel};
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // issue / wait / present sequencing; every output holds unless explicitly updated
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    res_d     = res_q;
    zflag_d   = zflag_q;
    res_sel_d = res_sel_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          a_d     = head.a;
          b_d     = head.b;
          sel_d   = head.sel;
          wcnt_d  = LAT_W'(ALU_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // counter hits zero one edge before capture; the extra edge is the ALU sampling its inputs
        if (wcnt_q == '0) begin
          res_d     = i_ul_r;
          zflag_d   = i_bi_zflag;
          res_sel_d = sel_q;
          illegal_d = (sel_q > 3'd5);
          valid_d   = 1'b1;
          state_d   = S_DONE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.i_bi_res_ready) begin
          valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            a_d     = head.a;
            b_d     = head.b;
            sel_d   = head.sel;
            wcnt_d  = LAT_W'(ALU_LAT);
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state, FIFO control and output registers; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      res_q     <= '0;
      zflag_q   <= 1'b0;
      res_sel_q <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      res_q     <= res_d;
      zflag_q   <= zflag_d;
      res_sel_q <= res_sel_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] dut_a;
  logic [31:0] dut_b;
  logic [2:0]  dut_sel;
  logic [31:0] alu_r;
  logic        alu_z;
  logic        busy;

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   last_cyc;
  bit   gap_chk;
  exp_t exp_q[$];
  exp_t mon_e;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .DEPTH   (4),
    .ALU_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_ul_a     (dut_a),
    .o_ul_b     (dut_b),
    .o_u3_sel   (dut_sel),
    .i_ul_r     (alu_r),
    .i_bi_zflag (alu_z),
    .o_bi_busy  (busy)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cycle counter for result spacing
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] sel);
    case (sel)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a & b;
      3'd2:    alu_f = a | b;
      3'd3:    alu_f = a ^ b;
      3'd4:    alu_f = a - b;
      3'd5:    alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = 32'd0;
    endcase
  endfunction

  // registered ALU, one edge of latency
  always @(posedge clk) begin
    alu_r <= alu_f(dut_a, dut_b, dut_sel);
    alu_z <= (alu_f(dut_a, dut_b, dut_sel) == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                          input logic [31:0] er, input logic ez, input logic eill,
                          output int waits);
    exp_t e;
    waits = 0;
    bus.i_ul_cmd_a     = a;
    bus.i_ul_cmd_b     = b;
    bus.i_u3_cmd_sel   = sel;
    bus.i_bi_cmd_valid = 1'b1;
    while (!bus.o_bi_cmd_ready && waits < 50) begin
      tick();
      waits++;
    end
    if (!bus.o_bi_cmd_ready) begin
      check("push_timeout", 32'd0, 32'd1);
    end else begin
      e.r = er; e.z = ez; e.sel = sel; e.ill = eill;
      exp_q.push_back(e);
    end
    tick();
    bus.i_bi_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // scoreboard: every consumed result is compared against the hand-computed queue
  always @(negedge clk) begin
    if (!rst && bus.o_bi_res_valid && bus.i_bi_res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res", bus.o_ul_res, mon_e.r);
        check("res_zflag", 32'(bus.o_bi_res_zflag), 32'(mon_e.z));
        check("res_sel", 32'(bus.o_u3_res_sel), 32'(mon_e.sel));
        check("res_illegal", 32'(bus.o_bi_res_illegal), 32'(mon_e.ill));
      end
      if (gap_chk) begin
        if (last_cyc >= 0) check("res_gap", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_checks = 0;
    n_errors = 0;
    gap_chk  = 1'b0;
    last_cyc = -1;
    rst                = 1'b1;
    bus.i_ul_cmd_a     = '0;
    bus.i_ul_cmd_b     = '0;
    bus.i_u3_cmd_sel   = '0;
    bus.i_bi_cmd_valid = 1'b0;
    bus.i_bi_res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_cmd_ready", 32'(bus.o_bi_cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.o_bi_res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_a", dut_a, 32'd0);

    // ADD 5+7: issue one edge after push, capture two edges after issue
    push_cmd(32'd5, 32'd7, 3'd0, 32'd12, 1'b0, 1'b0, w);
    check("t1_not_issued", dut_a, 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_issue_a", dut_a, 32'd5);
    check("t1_issue_b", dut_b, 32'd7);
    check("t1_issue_sel", 32'(dut_sel), 32'd0);
    check("t1_valid_e1", 32'(bus.o_bi_res_valid), 32'd0);
    tick();
    check("t1_valid_e2", 32'(bus.o_bi_res_valid), 32'd0);
    tick();
    check("t1_valid_e3", 32'(bus.o_bi_res_valid), 32'd1);
    check("t1_res", bus.o_ul_res, 32'd12);
    tick();
    check("t1_valid_drop", 32'(bus.o_bi_res_valid), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // SUB to zero, then SLT
    push_cmd(32'd9, 32'd9, 3'd4, 32'd0, 1'b1, 1'b0, w);
    wait_idle();
    push_cmd(32'd3, 32'd8, 3'd5, 32'd1, 1'b0, 1'b0, w);
    wait_idle();

    // illegal opcode 7
    push_cmd(32'd1, 32'd1, 3'd7, 32'd0, 1'b1, 1'b1, w);
    wait_idle();

    // fill with the sink stalled; write pointer wraps on the fifth push
    bus.i_bi_res_ready = 1'b0;
    push_cmd(32'd1,   32'd2,   3'd0, 32'd3,     1'b0, 1'b0, w);
    check("fill_w0", 32'(w), 32'd0);
    push_cmd(32'd9,   32'd4,   3'd4, 32'd5,     1'b0, 1'b0, w);
    check("fill_w1", 32'(w), 32'd0);
    push_cmd(32'd2,   32'd9,   3'd5, 32'd1,     1'b0, 1'b0, w);
    check("fill_w2", 32'(w), 32'd0);
    push_cmd(32'd100, 32'd200, 3'd0, 32'h12C,   1'b0, 1'b0, w);
    check("fill_w3", 32'(w), 32'd0);
    push_cmd(32'd7,   32'd7,   3'd4, 32'd0,     1'b1, 1'b0, w);
    check("fill_w4", 32'(w), 32'd0);
    check("full_cmd_ready", 32'(bus.o_bi_cmd_ready), 32'd0);
    check("full_issued_a", dut_a, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(bus.o_bi_res_valid), 32'd1);
      check("hold_res", bus.o_ul_res, 32'd3);
      tick();
    end

    // release the sink while a push is offered to the full FIFO: the pop edge must reject it
    gap_chk  = 1'b1;
    last_cyc = -1;
    bus.i_bi_res_ready = 1'b1;
    push_cmd(32'd0, 32'd0, 3'd0, 32'd0, 1'b1, 1'b0, w);
    check("full_pop_push_rejected", 32'(w), 32'd1);
    wait_idle();
    gap_chk = 1'b0;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // reset during WAIT with two commands queued
    push_cmd(32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 1'b1, 1'b0, w);
    push_cmd(32'd1, 32'd1, 3'd0, 32'd2, 1'b0, 1'b0, w);
    push_cmd(32'd2, 32'd2, 3'd0, 32'd4, 1'b0, 1'b0, w);
    check("pre_rst_a", dut_a, 32'hFFFF_FFFF);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_valid", 32'(bus.o_bi_res_valid), 32'd0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_a", dut_a, 32'd0);
    check("mid_rst_b", dut_b, 32'd0);
    check("mid_rst_sel", 32'(dut_sel), 32'd0);
    check("mid_rst_res", bus.o_ul_res, 32'd0);
    check("mid_rst_zflag", 32'(bus.o_bi_res_zflag), 32'd0);
    check("mid_rst_res_sel", 32'(bus.o_u3_res_sel), 32'd0);
    check("mid_rst_illegal", 32'(bus.o_bi_res_illegal), 32'd0);
    check("mid_rst_valid", 32'(bus.o_bi_res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_valid", 32'(bus.o_bi_res_valid), 32'd0);
    end
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cmd_ready", 32'(bus.o_bi_cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
